// File: rtl/audipus_enc_pkg.sv
// audipus_enc_pkg: shared arbiter state type, event-word field positions and encoder register width
package audipus_enc_pkg;
    typedef enum logic [1:0] {SCAN, ACK, SETTLE} ArbState;
    localparam int ENC_REG_W  = 8;
    localparam int EV_IDX_MSB = 7;
    localparam int EV_IDX_LSB = 5;
    localparam int EV_LOST    = 4;
    localparam int EV_CW      = 2;
    localparam int EV_VAL_MSB = 1;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; push/push_data write, pop drops head, data=head (0 when empty), count/empty/full status, sync active-low reset
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == CW'(DEPTH);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        data    = empty ? '0 : mem_q[rd_q];
        count   = cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
endmodule

// File: rtl/encoder_event_arbiter.sv
// encoder_event_arbiter: round-robin scan of enc_state_change, one-cycle enc_rd_stb ack, tagged events into FWFT FIFO (event_data/event_valid/fifo_count, cpu_rd_stb pop), sticky overflow with overflow_clr, registered irq gated by irq_en
module encoder_event_arbiter
    import audipus_enc_pkg::*;
#(
    parameter int NUM_ENC    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_ENC-1:0]             enc_state_change,
    input  logic [ENC_REG_W*NUM_ENC-1:0]   rotary_encoder_reg,
    output logic [NUM_ENC-1:0]             enc_rd_stb,
    input  logic                           cpu_rd_stb,
    input  logic                           overflow_clr,
    input  logic                           irq_en,
    output logic [7:0]                     event_data,
    output logic                           event_valid,
    output logic [4:0]                     fifo_count,
    output logic                           overflow,
    output logic                           irq
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    ArbState state_q, state_d;
    logic [2:0] ptr_q, ptr_d, ptr_nxt, cur;
    logic ovf_q, ovf_d, lost_q, lost_d, irq_q, irq_d;
    logic [NUM_ENC-1:0] sel;
    logic hit, push, full, empty;
    logic [7:0] ev;
    logic [CW-1:0] count;
    always_comb begin
        sel     = NUM_ENC'(1) << ptr_q;
        hit     = |(enc_state_change & sel);
        cur     = 3'(rotary_encoder_reg >> {ptr_q, 3'b000});
        ptr_nxt = (ptr_q == 3'(NUM_ENC-1)) ? 3'd0 : ptr_q + 3'd1;
        ev                        = '0;
        ev[EV_IDX_MSB:EV_IDX_LSB] = ptr_q;
        ev[EV_LOST]               = lost_q;
        ev[EV_CW]                 = cur[EV_CW];
        ev[EV_VAL_MSB:0]          = cur[EV_VAL_MSB:0];
    end
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lost_d     = lost_q;
        ovf_d      = overflow_clr ? 1'b0 : ovf_q;
        push       = 1'b0;
        enc_rd_stb = '0;
        irq_d      = ~empty & irq_en;
        case (state_q)
            SCAN: begin
                if (hit && !full) state_d = ACK;
                else begin
                    ptr_d = ptr_nxt;
                    if (hit) begin
                        ovf_d  = 1'b1;
                        lost_d = 1'b1;
                    end
                end
            end
            ACK: begin
                enc_rd_stb = sel;
                push       = 1'b1;
                lost_d     = 1'b0;
                state_d    = SETTLE;
            end
            default: begin
                ptr_d   = ptr_nxt;
                state_d = SCAN;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
            irq_q   <= irq_d;
        end
    end
    sync_fifo_fwft #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (ev),
        .pop       (cpu_rd_stb),
        .data      (event_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );
    always_comb begin
        event_valid = ~empty;
        fifo_count  = 5'(count);
        overflow    = ovf_q;
        irq         = irq_q;
    end
endmodule

// File: tb/tb_encoder_event_arbiter.sv
// tb_encoder_event_arbiter: randomized encoder/CPU stimulus checked cycle by cycle against a queue-based reference model
module tb_encoder_event_arbiter;
    localparam int N = 4;
    localparam int D = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] flag = '0;
    logic [8*N-1:0] regs = '0;
    logic cpu_rd_stb = 1'b0, overflow_clr = 1'b0, irq_en = 1'b0;
    logic [N-1:0] enc_rd_stb;
    logic [7:0] event_data;
    logic event_valid, overflow, irq;
    logic [4:0] fifo_count;
    int n_chk = 0, n_err = 0;
    int m_ptr = 0, m_left = 0;
    bit m_lost = 0, m_ovf = 0, m_irq = 0;
    logic [7:0] m_q[$];
    always #5 clk = ~clk;
    encoder_event_arbiter #(.NUM_ENC(N), .FIFO_DEPTH(D)) dut (
        .clk                (clk),
        .reset              (reset),
        .enc_state_change   (flag),
        .rotary_encoder_reg (regs),
        .enc_rd_stb         (enc_rd_stb),
        .cpu_rd_stb         (cpu_rd_stb),
        .overflow_clr       (overflow_clr),
        .irq_en             (irq_en),
        .event_data         (event_data),
        .event_valid        (event_valid),
        .fifo_count         (fifo_count),
        .overflow           (overflow),
        .irq                (irq)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // m_left counts remaining service cycles: 2 = acknowledging now, 1 = settling, 0 = scanning
    task automatic model_edge(output int acked);
        int sz;
        acked = -1;
        if (!reset) begin
            m_ptr = 0; m_left = 0; m_lost = 0; m_ovf = 0; m_irq = 0;
            m_q.delete();
            return;
        end
        sz = m_q.size();
        m_irq = (sz > 0) && irq_en;
        if (overflow_clr) m_ovf = 0;
        if (cpu_rd_stb && sz > 0) void'(m_q.pop_front());
        if (m_left == 2) begin
            m_q.push_back({3'(m_ptr), m_lost, 1'b0, regs[8*m_ptr +: 3]});
            m_lost = 0;
            acked = m_ptr;
            m_left = 1;
        end else if (m_left == 1) begin
            m_ptr = (m_ptr + 1) % N;
            m_left = 0;
        end else if (flag[m_ptr] && sz < D) begin
            m_left = 2;
        end else begin
            if (flag[m_ptr]) begin
                m_ovf = 1;
                m_lost = 1;
            end
            m_ptr = (m_ptr + 1) % N;
        end
    endtask
    task automatic run(input int n, input int pf, input int pp, input int pc, input int pr);
        int acked;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge(acked);
            #1;
            chk("enc_rd_stb", 32'(enc_rd_stb), (m_left == 2) ? (32'd1 << m_ptr) : 32'd0);
            chk("event_valid", 32'(event_valid), 32'(m_q.size() > 0));
            chk("event_data", 32'(event_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("irq", 32'(irq), 32'(m_irq));
            if (acked >= 0) flag[acked] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (pf > 0 && !flag[i] && $urandom_range(99) < pf) begin
                    flag[i] = 1'b1;
                    regs[8*i +: 8] = 8'($urandom);
                end else if (pf > 0 && flag[i] && $urandom_range(99) < 10) begin
                    regs[8*i +: 8] = 8'($urandom);
                end
            end
            if (pp >= 0) cpu_rd_stb = $urandom_range(99) < pp;
            if (pc >= 0) overflow_clr = $urandom_range(99) < pc;
            if (pr > 0) begin
                reset = $urandom_range(999) >= pr;
                irq_en = $urandom_range(9) != 0;
            end
        end
    endtask
    initial begin
        run(3, 0, 0, 0, 0);
        reset = 1'b1;
        irq_en = 1'b1;
        flag[2] = 1'b1;
        regs[23:16] = 8'h05;
        run(8, 0, 0, 0, 0);
        run(2, 0, 100, 0, 0);
        cpu_rd_stb = 1'b0;
        flag = '1;
        regs = 32'h1F_0A_36_C7;
        run(16, 0, 0, 0, 0);
        run(250, 60, 0, 20, 0);
        run(10, 0, 100, 0, 0);
        run(3, 0, 0, 100, 0);
        run(1500, 30, 35, 10, 8);
        reset = 1'b1;
        run(60, 0, 100, 100, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
